// File: rtl/lcd_reader.sv
// Seven-segment display scanner: captures stable digits and assembles
// them into 16-bit frames handed off with a valid/ready handshake.
module lcd_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    input  logic        rd_ready,
    output logic [15:0] hex,
    output logic        valid,
    output logic        err
);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    localparam logic [3:0] CAP_CNT = 4'(STABLE_CYCLES - 2);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;
    logic [3:0]  cnt_q;
    logic [15:0] buf_q;
    logic [15:0] buf_d;
    logic [3:0]  seen_q;
    logic [3:0]  seen_d;
    logic        err_pend_q;
    logic        err_pend_d;
    logic        same;
    logic        cap;
    logic [3:0]  cap_mask;
    logic [4:0]  dec;
    logic        load;
    logic        xfer;

    // {ok, nibble}; nibble is 0 for undecodable patterns
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h27:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h46:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h3D:   r = 5'h1B;
            7'h78:   r = 5'h1C;
            7'h1F:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Capture on the edge that takes the STABLE_CYCLES-th identical sample
    always_comb begin
        same     = (an == an_q) && (seg == seg_q);
        dec      = decode(seg);
        cap      = same && (cnt_q == CAP_CNT) && $onehot(an);
        cap_mask = cap ? an : 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (seen_q == 4'hF) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rd_ready) begin
                    xfer    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // A capture on the load edge belongs to the next frame
    always_comb begin
        buf_d      = buf_q;
        seen_d     = (load ? 4'b0000 : seen_q) | cap_mask;
        err_pend_d = (load ? 1'b0 : err_pend_q) | (cap & ~dec[4]);
        for (int i = 0; i < 4; i++) begin
            if (cap_mask[i]) begin
                buf_d[4*i +: 4] = dec[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q       <= 4'b0000;
            seg_q      <= 7'b0000000;
            cnt_q      <= 4'd0;
            buf_q      <= 16'h0000;
            seen_q     <= 4'b0000;
            err_pend_q <= 1'b0;
            hex        <= 16'h0000;
            valid      <= 1'b0;
            err        <= 1'b0;
        end else begin
            an_q       <= an;
            seg_q      <= seg;
            if (same) begin
                cnt_q <= (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_q <= 4'd0;
            end
            buf_q      <= buf_d;
            seen_q     <= seen_d;
            err_pend_q <= err_pend_d;
            if (load) begin
                hex   <= buf_q;
                err   <= err_pend_q;
                valid <= 1'b1;
            end else if (xfer) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: directed scenarios plus random scan traffic
// checked every cycle against a run-length based frame model.
module tb_lcd_reader;

    localparam int S = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rd_ready;
    logic [15:0] hex;
    logic        valid;
    logic        err;

    lcd_reader #(.STABLE_CYCLES(S)) dut (
        .clk      (clk),
        .reset    (reset),
        .an       (an),
        .seg      (seg),
        .rd_ready (rd_ready),
        .hex      (hex),
        .valid    (valid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    logic [6:0] pat [16] = '{
        7'h7E, 7'h06, 7'h5B, 7'h4F,
        7'h27, 7'h6D, 7'h7D, 7'h46,
        7'h7F, 7'h6F, 7'h77, 7'h3D,
        7'h78, 7'h1F, 7'h79, 7'h71
    };

    int         m_buf [4];
    logic [3:0] m_seen;
    logic       m_errp;
    logic [15:0] m_hex;
    logic       m_valid;
    logic       m_err;
    logic [3:0] p_an;
    logic [6:0] p_seg;
    int         run;

    int          valid_cnt;
    logic [15:0] got_hex;
    logic        got_err;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (pat[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_buf[i] = 0;
        m_seen  = 4'b0;
        m_errp  = 1'b0;
        m_hex   = 16'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        p_an    = 4'b0;
        p_seg   = 7'b0;
        run     = 0;
    endtask

    task automatic model_edge(input logic [3:0] a, input logic [6:0] s,
                              input logic r);
        int d;
        if (a == p_an && s == p_seg) run++;
        else run = 1;
        p_an  = a;
        p_seg = s;
        if (!m_valid && m_seen == 4'hF) begin
            m_hex   = 16'(m_buf[0] + 16 * m_buf[1]
                      + 256 * m_buf[2] + 4096 * m_buf[3]);
            m_err   = m_errp;
            m_valid = 1'b1;
            m_seen  = 4'b0;
            m_errp  = 1'b0;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (run == S && $countones(a) == 1) begin
            d = model_decode(s);
            for (int i = 0; i < 4; i++) begin
                if (a[i]) begin
                    m_buf[i]  = (d < 0) ? 0 : d;
                    m_seen[i] = 1'b1;
                end
            end
            if (d < 0) m_errp = 1'b1;
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s,
                        input logic r);
        an       = a;
        seg      = s;
        rd_ready = r;
        @(posedge clk);
        model_edge(a, s, r);
        @(negedge clk);
        chk("hex", hex, m_hex);
        chk("valid", 16'(valid), 16'(m_valid));
        chk("err", 16'(err), 16'(m_err));
        if (valid) begin
            valid_cnt++;
            got_hex = hex;
            got_err = err;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s,
                        input logic r, input int n);
        for (int i = 0; i < n; i++) step(a, s, r);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic r);
        hold(4'b0001, s0, r, S);
        hold(4'b0010, s1, r, S);
        hold(4'b0100, s2, r, S);
        hold(4'b1000, s3, r, S);
    endtask

    task automatic do_reset();
        an       = 4'b0;
        seg      = 7'b0;
        rd_ready = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        chk("rst_hex", hex, 16'h0);
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_seen", 16'(dut.seen_q), 16'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        int         rn;
        n_assert  = 0;
        n_fail    = 0;
        valid_cnt = 0;
        got_hex   = 16'h0;
        got_err   = 1'b0;
        reset     = 1'b1;
        an        = 4'b0;
        seg       = 7'b0;
        rd_ready  = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        valid_cnt = 0;
        frame(7'h06, 7'h5B, 7'h4F, 7'h27, 1'b1);
        hold(4'b0, 7'b0, 1'b1, 3);
        chk("f1_vcycles", 16'(valid_cnt), 16'd1);
        chk("f1_hex", got_hex, 16'h4321);
        chk("f1_err", 16'(got_err), 16'h0);

        do_reset();
        hold(4'b0001, 7'h7E, 1'b0, S - 1);
        hold(4'b0001, 7'h06, 1'b0, 1);
        chk("short_seen0", 16'(dut.seen_q[0]), 16'h0);

        do_reset();
        frame(7'h7F, 7'h7F, 7'h00, 7'h7F, 1'b0);
        step(4'b0, 7'b0, 1'b0);
        chk("bad_hex", hex, 16'h8088);
        chk("bad_err", 16'(err), 16'h1);
        chk("bad_valid", 16'(valid), 16'h1);

        do_reset();
        frame(7'h27, 7'h4F, 7'h5B, 7'h06, 1'b0);
        step(4'b0, 7'b0, 1'b0);
        chk("a_hex", hex, 16'h1234);
        frame(7'h1F, 7'h78, 7'h3D, 7'h77, 1'b0);
        hold(4'b0, 7'b0, 1'b0, 2);
        chk("a_held", hex, 16'h1234);
        chk("a_valid", 16'(valid), 16'h1);
        step(4'b0, 7'b0, 1'b1);
        chk("gap_valid", 16'(valid), 16'h0);
        step(4'b0, 7'b0, 1'b0);
        chk("b_hex", hex, 16'hABCD);
        chk("b_valid", 16'(valid), 16'h1);

        do_reset();
        hold(4'b0011, 7'h06, 1'b1, 10);
        hold(4'b0000, 7'h06, 1'b1, 10);
        chk("mh_seen", 16'(dut.seen_q), 16'h0);
        chk("mh_valid", 16'(valid), 16'h0);

        do_reset();
        hold(4'b0001, 7'h06, 1'b0, S);
        hold(4'b0010, 7'h5B, 1'b0, S);
        hold(4'b0100, 7'h4F, 1'b0, S);
        chk("pre_seen", 16'(dut.seen_q), 16'h7);
        @(posedge clk);
        #2;
        do_reset();
        frame(7'h6D, 7'h7D, 7'h46, 7'h7F, 1'b0);
        step(4'b0, 7'b0, 1'b0);
        chk("post_hex", hex, 16'h8765);
        chk("post_err", 16'(err), 16'h0);

        do_reset();
        for (int k = 0; k < 250; k++) begin
            rn = $urandom_range(0, 9);
            if (rn < 7) ra = 4'(1 << $urandom_range(0, 3));
            else if (rn == 7) ra = 4'b0;
            else ra = 4'($urandom);
            if ($urandom_range(0, 3) == 0) rs = 7'($urandom);
            else rs = pat[$urandom_range(0, 15)];
            rn = $urandom_range(1, 7);
            for (int j = 0; j < rn; j++) begin
                step(ra, rs, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
